// File: rtl/token_engine_pkg.sv
// Shared types and constants for the token-engine GLB arbiter.
package token_engine_pkg;

  typedef enum logic [1:0] {CLS_IFMAP, CLS_IPSUM, CLS_OPSUM} glb_class_e;

  typedef enum logic [2:0] {IDLE, GRANT, RD_ISSUE, RD_RESP, WRITE} arb_state_e;

  localparam logic [3:0] GLB_WEB_READ = 4'hF;
  localparam int         NUM_CH_DEF   = 32;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: lowest set request at or after i_ptr, wrapping at N.
module rr_arbiter #(
  parameter int N  = 32,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_gnt_idx,
  output logic          o_any
);

  int w_j;

  always_comb begin
    o_gnt     = '0;
    o_gnt_idx = '0;
    o_any     = 1'b0;
    w_j       = 0;
    for (int i = 0; i < N; i++) begin
      w_j = (int'(i_ptr) + i) % N;
      if (!o_any && i_req[w_j]) begin
        o_any     = 1'b1;
        o_gnt[w_j] = 1'b1;
        o_gnt_idx = IW'(w_j);
      end
    end
  end

endmodule

// File: rtl/fifo_glb_arbiter.sv
// Single-port GLB arbiter for ifmap/ipsum reads and opsum writes (opsum > ipsum > ifmap, RR per class).
// Optional ARB_PERF_CNT_EN adds saturating grant/conflict counters.
module fifo_glb_arbiter
  import token_engine_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_CH-1:0]              ifmap_read_req_matrix_i,
  input  logic [NUM_CH-1:0][ADDR_W-1:0]  ifmap_glb_read_addr_matrix_i,
  input  logic [NUM_CH-1:0]              ipsum_read_req_matrix_i,
  input  logic [NUM_CH-1:0][ADDR_W-1:0]  ipsum_glb_read_addr_matrix_i,
  input  logic [NUM_CH-1:0]              opsum_glb_write_req_matrix_i,
  input  logic [NUM_CH-1:0][ADDR_W-1:0]  opsum_glb_write_addr_matrix_i,
  input  logic [NUM_CH-1:0][3:0]         opsum_glb_write_web_matrix_i,
  input  logic [NUM_CH-1:0][DATA_W-1:0]  opsum_fifo_pop_data_matrix_i,
  input  logic [DATA_W-1:0]              glb_rdata_i,
  output logic                           glb_en_o,
  output logic [3:0]                     glb_web_o,
  output logic [ADDR_W-1:0]              glb_addr_o,
  output logic [DATA_W-1:0]              glb_wdata_o,
  output logic [NUM_CH-1:0]              ifmap_permit_push_matrix_o,
  output logic [NUM_CH-1:0]              ipsum_permit_push_matrix_o,
  output logic [NUM_CH-1:0]              opsum_permit_pop_matrix_o,
  output logic [DATA_W-1:0]              glb_read_data_o,
  output logic                           fifo_glb_busy_o
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]                    perf_ifmap_grant_o,
  output logic [31:0]                    perf_ipsum_grant_o,
  output logic [31:0]                    perf_opsum_grant_o,
  output logic [31:0]                    perf_conflict_o
`endif
);

  localparam int IW = $clog2(NUM_CH);

  arb_state_e        r_state, w_state_nxt;
  glb_class_e        r_cls;
  logic [NUM_CH-1:0] r_oh;
  logic [ADDR_W-1:0] r_addr;
  logic [3:0]        r_web;
  logic [DATA_W-1:0] r_wdata;
  logic [IW-1:0]     r_ptr_if, r_ptr_ip, r_ptr_op;

  logic [NUM_CH-1:0] w_if_gnt, w_ip_gnt, w_op_gnt;
  logic [IW-1:0]     w_if_idx, w_ip_idx, w_op_idx;
  logic              w_if_any, w_ip_any, w_op_any;

  logic              w_sel_valid;
  glb_class_e        w_sel_cls;
  logic [IW-1:0]     w_sel_idx;
  logic [NUM_CH-1:0] w_sel_oh;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [3:0]        w_sel_web;
  logic [DATA_W-1:0] w_sel_wdata;

  logic              w_any_req, w_pend_masked, w_grant_fire;

  rr_arbiter #(.N(NUM_CH), .IW(IW)) u_rr_ifmap (
    .i_req(ifmap_read_req_matrix_i), .i_ptr(r_ptr_if),
    .o_gnt(w_if_gnt), .o_gnt_idx(w_if_idx), .o_any(w_if_any));

  rr_arbiter #(.N(NUM_CH), .IW(IW)) u_rr_ipsum (
    .i_req(ipsum_read_req_matrix_i), .i_ptr(r_ptr_ip),
    .o_gnt(w_ip_gnt), .o_gnt_idx(w_ip_idx), .o_any(w_ip_any));

  rr_arbiter #(.N(NUM_CH), .IW(IW)) u_rr_opsum (
    .i_req(opsum_glb_write_req_matrix_i), .i_ptr(r_ptr_op),
    .o_gnt(w_op_gnt), .o_gnt_idx(w_op_idx), .o_any(w_op_any));

  // Fixed class priority so opsum draining never waits behind reads.
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_cls   = CLS_IFMAP;
    w_sel_idx   = '0;
    w_sel_oh    = '0;
    w_sel_addr  = '0;
    w_sel_web   = GLB_WEB_READ;
    w_sel_wdata = '0;
    if (w_op_any) begin
      w_sel_valid = 1'b1;
      w_sel_cls   = CLS_OPSUM;
      w_sel_idx   = w_op_idx;
      w_sel_oh    = w_op_gnt;
      w_sel_addr  = opsum_glb_write_addr_matrix_i[w_op_idx];
      w_sel_web   = opsum_glb_write_web_matrix_i[w_op_idx];
      w_sel_wdata = opsum_fifo_pop_data_matrix_i[w_op_idx];
    end else if (w_ip_any) begin
      w_sel_valid = 1'b1;
      w_sel_cls   = CLS_IPSUM;
      w_sel_idx   = w_ip_idx;
      w_sel_oh    = w_ip_gnt;
      w_sel_addr  = ipsum_glb_read_addr_matrix_i[w_ip_idx];
    end else if (w_if_any) begin
      w_sel_valid = 1'b1;
      w_sel_idx   = w_if_idx;
      w_sel_oh    = w_if_gnt;
      w_sel_addr  = ifmap_glb_read_addr_matrix_i[w_if_idx];
    end
  end

  assign w_grant_fire = (r_state == GRANT) && w_sel_valid;
  assign w_any_req    = |ifmap_read_req_matrix_i | |ipsum_read_req_matrix_i
                      | |opsum_glb_write_req_matrix_i;

  assign ifmap_permit_push_matrix_o = (r_state == RD_RESP && r_cls == CLS_IFMAP) ? r_oh : '0;
  assign ipsum_permit_push_matrix_o = (r_state == RD_RESP && r_cls == CLS_IPSUM) ? r_oh : '0;
  assign opsum_permit_pop_matrix_o  = (r_state == WRITE) ? r_oh : '0;

  // The requester being served this cycle still shows req; it must not trigger another grant.
  assign w_pend_masked = |(ifmap_read_req_matrix_i      & ~ifmap_permit_push_matrix_o)
                       | |(ipsum_read_req_matrix_i      & ~ipsum_permit_push_matrix_o)
                       | |(opsum_glb_write_req_matrix_i & ~opsum_permit_pop_matrix_o);

  always_comb begin
    w_state_nxt     = r_state;
    glb_en_o        = 1'b0;
    glb_web_o       = GLB_WEB_READ;
    glb_addr_o      = '0;
    glb_wdata_o     = '0;
    glb_read_data_o = '0;
    fifo_glb_busy_o = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any_req) w_state_nxt = GRANT;
      end
      GRANT: begin
        if (!w_sel_valid)                w_state_nxt = IDLE;
        else if (w_sel_cls == CLS_OPSUM) w_state_nxt = WRITE;
        else                             w_state_nxt = RD_ISSUE;
      end
      RD_ISSUE: begin
        glb_en_o        = 1'b1;
        glb_addr_o      = r_addr;
        fifo_glb_busy_o = 1'b1;
        w_state_nxt     = RD_RESP;
      end
      RD_RESP: begin
        glb_read_data_o = glb_rdata_i;
        fifo_glb_busy_o = 1'b1;
        w_state_nxt     = w_pend_masked ? GRANT : IDLE;
      end
      WRITE: begin
        glb_en_o        = 1'b1;
        glb_web_o       = r_web;
        glb_addr_o      = r_addr;
        glb_wdata_o     = r_wdata;
        fifo_glb_busy_o = 1'b1;
        w_state_nxt     = w_pend_masked ? GRANT : IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cls    <= CLS_IFMAP;
      r_oh     <= '0;
      r_addr   <= '0;
      r_web    <= GLB_WEB_READ;
      r_wdata  <= '0;
      r_ptr_if <= '0;
      r_ptr_ip <= '0;
      r_ptr_op <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant_fire) begin
        r_cls   <= w_sel_cls;
        r_oh    <= w_sel_oh;
        r_addr  <= w_sel_addr;
        r_web   <= w_sel_web;
        r_wdata <= w_sel_wdata;
        case (w_sel_cls)
          CLS_OPSUM: r_ptr_op <= (w_sel_idx == IW'(NUM_CH - 1)) ? '0 : w_sel_idx + 1'b1;
          CLS_IPSUM: r_ptr_ip <= (w_sel_idx == IW'(NUM_CH - 1)) ? '0 : w_sel_idx + 1'b1;
          default:   r_ptr_if <= (w_sel_idx == IW'(NUM_CH - 1)) ? '0 : w_sel_idx + 1'b1;
        endcase
      end
    end
  end

`ifdef ARB_PERF_CNT_EN
  logic [31:0] r_perf_if, r_perf_ip, r_perf_op, r_perf_cf;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_if <= '0;
      r_perf_ip <= '0;
      r_perf_op <= '0;
      r_perf_cf <= '0;
    end else begin
      if (w_grant_fire) begin
        case (w_sel_cls)
          CLS_OPSUM: r_perf_op <= sat_inc32(r_perf_op);
          CLS_IPSUM: r_perf_ip <= sat_inc32(r_perf_ip);
          default:   r_perf_if <= sat_inc32(r_perf_if);
        endcase
      end
      if (w_any_req && fifo_glb_busy_o) r_perf_cf <= sat_inc32(r_perf_cf);
    end
  end

  assign perf_ifmap_grant_o = r_perf_if;
  assign perf_ipsum_grant_o = r_perf_ip;
  assign perf_opsum_grant_o = r_perf_op;
  assign perf_conflict_o    = r_perf_cf;
`endif

endmodule

// File: tb/tb_fifo_glb_arbiter.sv
// Directed self-checking bench for fifo_glb_arbiter; perf counter checks need ARB_PERF_CNT_EN.
module tb_fifo_glb_arbiter;

  localparam int NUM_CH = 32;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic                          clk = 1'b0;
  logic                          rst;
  logic [NUM_CH-1:0]             if_req, ip_req, op_req;
  logic [NUM_CH-1:0][ADDR_W-1:0] if_addr, ip_addr, op_addr;
  logic [NUM_CH-1:0][3:0]        op_web;
  logic [NUM_CH-1:0][DATA_W-1:0] op_data;
  logic [DATA_W-1:0]             rdata;
  logic                          en;
  logic [3:0]                    web;
  logic [ADDR_W-1:0]             addr;
  logic [DATA_W-1:0]             wdata;
  logic [NUM_CH-1:0]             if_push, ip_push, op_pop;
  logic [DATA_W-1:0]             rd_out;
  logic                          busy;
`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_if, perf_ip, perf_op, perf_cf;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fifo_glb_arbiter #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .ifmap_read_req_matrix_i(if_req),
    .ifmap_glb_read_addr_matrix_i(if_addr),
    .ipsum_read_req_matrix_i(ip_req),
    .ipsum_glb_read_addr_matrix_i(ip_addr),
    .opsum_glb_write_req_matrix_i(op_req),
    .opsum_glb_write_addr_matrix_i(op_addr),
    .opsum_glb_write_web_matrix_i(op_web),
    .opsum_fifo_pop_data_matrix_i(op_data),
    .glb_rdata_i(rdata),
    .glb_en_o(en), .glb_web_o(web), .glb_addr_o(addr), .glb_wdata_o(wdata),
    .ifmap_permit_push_matrix_o(if_push),
    .ipsum_permit_push_matrix_o(ip_push),
    .opsum_permit_pop_matrix_o(op_pop),
    .glb_read_data_o(rd_out),
    .fifo_glb_busy_o(busy)
`ifdef ARB_PERF_CNT_EN
    ,
    .perf_ifmap_grant_o(perf_if), .perf_ipsum_grant_o(perf_ip),
    .perf_opsum_grant_o(perf_op), .perf_conflict_o(perf_cf)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Steps until one permit appears; cls 0=ifmap 1=ipsum 2=opsum, -1 on timeout.
  task automatic wait_permit(input bit clear, output int cls, output int idx,
                             output int lat, output logic [DATA_W-1:0] rd);
    int cnt;
    cls = -1; idx = -1; lat = -1; rd = '0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      cnt = $countones({op_pop, ip_push, if_push});
      chk("permit_at_most_one", 64'(cnt > 1), 64'd0);
      if (cnt == 1) begin
        for (int k = 0; k < NUM_CH; k++) begin
          if (if_push[k]) begin cls = 0; idx = k; end
          if (ip_push[k]) begin cls = 1; idx = k; end
          if (op_pop[k])  begin cls = 2; idx = k; end
        end
        lat = c;
        rd  = rd_out;
        break;
      end
    end
    if (clear && cls == 0) if_req[idx] = 1'b0;
    if (clear && cls == 1) ip_req[idx] = 1'b0;
    if (clear && cls == 2) op_req[idx] = 1'b0;
  endtask

  initial begin
    int cls, idx, lat;
    logic [DATA_W-1:0] rd;
    if_req = '0; ip_req = '0; op_req = '0;
    if_addr = '0; ip_addr = '0; op_addr = '0;
    op_web = '1; op_data = '0; rdata = '0;
    do_reset();

    chk("rst_en", 64'(en), 64'd0);
    chk("rst_web", 64'(web), 64'hF);
    chk("rst_addr", 64'(addr), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_permits", 64'($countones({op_pop, ip_push, if_push})), 64'd0);

    // 1: single ifmap read ch5
    if_addr[5] = 32'h100;
    if_req[5]  = 1'b1;
    tick();
    chk("t1_grant_busy", 64'(busy), 64'd0);
    chk("t1_grant_en", 64'(en), 64'd0);
    tick();
    chk("t1_issue_en", 64'(en), 64'd1);
    chk("t1_issue_addr", 64'(addr), 64'h100);
    chk("t1_issue_web", 64'(web), 64'hF);
    chk("t1_issue_busy", 64'(busy), 64'd1);
    rdata = 32'hDEAD;
    tick();
    chk("t1_push", 64'(if_push), 64'h20);
    chk("t1_rdata", 64'(rd_out), 64'hDEAD);
    chk("t1_resp_en", 64'(en), 64'd0);
    if_req[5] = 1'b0;
    tick();
    chk("t1_idle_busy", 64'(busy), 64'd0);
    chk("t1_idle_push", 64'(if_push), 64'd0);

    // 2: class priority opsum > ipsum > ifmap
    if_req[3] = 1'b1; ip_req[7] = 1'b1; op_req[1] = 1'b1;
    wait_permit(1'b1, cls, idx, lat, rd);
    chk("t2_first_cls", 64'(cls), 64'd2);
    chk("t2_first_idx", 64'(idx), 64'd1);
    chk("t2_first_lat", 64'(lat), 64'd2);
    wait_permit(1'b1, cls, idx, lat, rd);
    chk("t2_second_cls", 64'(cls), 64'd1);
    chk("t2_second_idx", 64'(idx), 64'd7);
    chk("t2_second_lat", 64'(lat), 64'd3);
    wait_permit(1'b1, cls, idx, lat, rd);
    chk("t2_third_cls", 64'(cls), 64'd0);
    chk("t2_third_idx", 64'(idx), 64'd3);
    chk("t2_third_lat", 64'(lat), 64'd3);
    tick();
    chk("t2_idle_busy", 64'(busy), 64'd0);

    // 3: round-robin with wrap, requests held throughout
    do_reset();
    if_req[0] = 1'b1; if_req[10] = 1'b1; if_req[31] = 1'b1;
    wait_permit(1'b0, cls, idx, lat, rd);
    chk("t3_g0", 64'(idx), 64'd0);
    wait_permit(1'b0, cls, idx, lat, rd);
    chk("t3_g1", 64'(idx), 64'd10);
    chk("t3_g1_lat", 64'(lat), 64'd3);
    wait_permit(1'b0, cls, idx, lat, rd);
    chk("t3_g2", 64'(idx), 64'd31);
    wait_permit(1'b0, cls, idx, lat, rd);
    chk("t3_g3_wrap", 64'(idx), 64'd0);
    chk("t3_g3_cls", 64'(cls), 64'd0);
    if_req = '0;
    tick();
    tick();
    chk("t3_idle_busy", 64'(busy), 64'd0);

    // 4: opsum write ch2, inputs change after capture
    op_addr[2] = 32'h40; op_web[2] = 4'h0; op_data[2] = 32'h1234;
    op_req[2]  = 1'b1;
    tick();
    chk("t4_grant_busy", 64'(busy), 64'd0);
    tick();
    op_addr[2] = 32'hFFF0; op_data[2] = 32'h5555; op_web[2] = 4'hA;
    #1;
    chk("t4_en", 64'(en), 64'd1);
    chk("t4_addr", 64'(addr), 64'h40);
    chk("t4_web", 64'(web), 64'h0);
    chk("t4_wdata", 64'(wdata), 64'h1234);
    chk("t4_pop", 64'(op_pop), 64'h4);
    chk("t4_busy", 64'(busy), 64'd1);
    op_req[2] = 1'b0;
    tick();
    chk("t4_after_busy", 64'(busy), 64'd0);
    chk("t4_after_web", 64'(web), 64'hF);
    chk("t4_after_wdata", 64'(wdata), 64'd0);

    // 5: reset during RD_ISSUE drops the transaction
    if_addr[9] = 32'h200; if_req[9] = 1'b1; rdata = 32'hBEEF;
    tick();
    tick();
    chk("t5_issue_addr", 64'(addr), 64'h200);
    rst = 1'b1;
    tick();
    chk("t5_rst_en", 64'(en), 64'd0);
    chk("t5_rst_web", 64'(web), 64'hF);
    chk("t5_rst_addr", 64'(addr), 64'd0);
    chk("t5_rst_busy", 64'(busy), 64'd0);
    chk("t5_rst_rdata", 64'(rd_out), 64'd0);
    chk("t5_rst_permits", 64'($countones({op_pop, ip_push, if_push})), 64'd0);
    rst = 1'b0;
    wait_permit(1'b1, cls, idx, lat, rd);
    chk("t5_retry_cls", 64'(cls), 64'd0);
    chk("t5_retry_idx", 64'(idx), 64'd9);
    chk("t5_retry_lat", 64'(lat), 64'd3);
    chk("t5_retry_rdata", 64'(rd), 64'hBEEF);

`ifdef ARB_PERF_CNT_EN
    // 6: counters after 3 opsum and 2 ifmap grants
    do_reset();
    op_req[0] = 1'b1; op_req[1] = 1'b1; op_req[2] = 1'b1;
    if_req[4] = 1'b1; if_req[5] = 1'b1;
    for (int n = 0; n < 5; n++) begin
      wait_permit(1'b1, cls, idx, lat, rd);
      chk("t6_order_cls", 64'(cls), (n < 3) ? 64'd2 : 64'd0);
    end
    tick();
    chk("t6_perf_opsum", 64'(perf_op), 64'd3);
    chk("t6_perf_ifmap", 64'(perf_if), 64'd2);
    chk("t6_perf_ipsum", 64'(perf_ip), 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
